cdb_broadcaster: RTL and testbench
==================================

Name: cdb_broadcaster

Overview:
- Transmit end of the common data bus (CDB): collects completed results from the functional units and drives the 4-lane CDB (valid, ROB index, 16-bit value) that the reorder buffer and reservation stations consume.
- Each functional unit (FU) has a small result queue; a round-robin arbiter grants up to 4 queue heads per cycle onto registered CDB lanes.
- Flush discards all pending results on mispredict.

Parameters:
- NUM_FU, 6, number of functional-unit producers (4..8)
- QUEUE_DEPTH, 2, result entries buffered per FU (power of two, >=2)

Ports:
- clk  input  1  clock, all state updates on posedge
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous discard of all queued and outgoing results
- fu_valid[0:NUM_FU-1]  input  1 each  FU presents a completed result
- fu_ready[0:NUM_FU-1]  output  1 each  queue can accept; transfer = fu_valid && fu_ready at posedge
- fu_indices[0:NUM_FU-1]  input  4 each  ROB index of the result
- fu_values[0:NUM_FU-1]  input  16 each  result value
- cdb_valid[0:3]  output  1 each  lane carries a result this cycle
- indices[0:3]  output  4 each  ROB index per lane
- new_values[0:3]  output  16 each  value per lane
- pending_count  output  5  total entries held across all FU queues

Behaviour:
- Reset (sync, highest priority): all queues empty; rr_ptr=0; cdb_valid all 0; indices and new_values 0; pending_count 0; fu_ready all 1 in the following cycle.
- Flush (below reset): same effect as reset on queues, cdb outputs and pending_count. rr_ptr is unchanged. Pushes offered in the flush cycle are dropped. fu_ready is still driven from pre-flush occupancy.
- fu_ready[k] = (count[k] < QUEUE_DEPTH), derived from registered occupancy only. It must not depend on fu_valid or on this cycle's grant (no combinational path).
- Each FU queue is FIFO with per-FU order preserved. Push and grant-pop of the same queue in one edge are legal: count is unchanged and the new entry lands behind the remaining ones.
- Arbitration each edge:
  - Scan FUs starting at rr_ptr and wrapping mod NUM_FU.
  - Grant the head of the first up-to-4 non-empty queues, at most one entry per FU per cycle.
  - Fill lanes contiguously from lane 0 in scan order; unused lanes get cdb_valid=0 and hold their previous indices/new_values.
  - Only entries present before the edge are eligible. An entry pushed at edge E is first eligible at edge E+1.
- rr_ptr update: if any grant, rr_ptr <= (last granted FU + 1) mod NUM_FU; if no grant, unchanged.
- Outputs are registered: a grant at edge E is visible on the CDB from E until edge E+1. Each result appears on the CDB exactly once, for exactly one cycle.
- Latency: minimum 2 edges from accepted push to CDB visibility (push at E, on bus after E+1).
- pending_count = sum of counts after the edge = old + pushes − grants. Range 0..NUM_FU*QUEUE_DEPTH.
- Arithmetic: rr_ptr wraps explicitly mod NUM_FU (NUM_FU need not be a power of two); queue pointers wrap mod QUEUE_DEPTH.
- No ordering guarantee across FUs, and no duplicate-index checking (producers guarantee unique in-flight ROB indices).
- With 5+ non-empty queues, the unserved FUs are served first next cycle via rr_ptr. Worst-case wait for any head is ceil(NUM_FU/4) cycles.
- fu_valid && !fu_ready: no transfer, no state change; producer must hold its data.

Test Plan:
- Reset, then FU2 pushes (index=5, value=0x1234) at edge 1 -> cdb_valid[0]=1, indices[0]=5, new_values[0]=0x1234 after edge 2 only; lanes 1-3 invalid; pending_count back to 0.
- All 6 FUs push index=k, value=0x100+k in one edge -> next cycle lanes 0-3 carry FUs 0,1,2,3 and rr_ptr=4; following cycle lanes 0,1 carry FUs 4,5 and lanes 2,3 invalid.
- FU0 pushes on 3 consecutive edges with no other traffic -> fu_ready[0] stays 1 (push and pop overlap), values appear on lane 0 in push order, one per cycle.
- Saturate FU1 by pushing while its queue is held non-empty and others starve it by rotation -> fu_ready[1]=0 when count=2; a push attempted while not ready is not stored (index never appears on the CDB).
- Fill 4 FU queues (pending_count=8), assert flush for one cycle -> next cycle cdb_valid all 0, pending_count=0, fu_ready all 1; none of the flushed indices ever appears on the CDB.
- Assert reset while lanes are active and queues are non-empty -> next cycle all outputs at reset values; a subsequent single push from FU5 is granted on lane 0 (rr_ptr=0 scan).

Source files
------------

// File: rtl/cdb_if.sv
// Result path between the functional units and the CDB transmitter,
// plus the registered 4-lane CDB it drives.
interface cdb_if #(
  parameter int NUM_FU = 6
);
  // Handshake: a result moves from FU k into its queue on a posedge where
  // fu_valid[k] && fu_ready[k]. fu_ready comes from registered occupancy only,
  // so a producer that sees it low must hold valid and data until it rises.
  logic [NUM_FU-1:0] fu_valid;
  logic [NUM_FU-1:0] fu_ready;
  logic [3:0]        fu_indices [NUM_FU];
  logic [15:0]       fu_values  [NUM_FU];
  logic [3:0]        cdb_valid;
  logic [3:0]        indices    [4];
  logic [15:0]       new_values [4];
  logic [4:0]        pending_count;

  modport master (
    output fu_valid, fu_indices, fu_values,
    input  fu_ready, cdb_valid, indices, new_values, pending_count
  );

  modport slave (
    input  fu_valid, fu_indices, fu_values,
    output fu_ready, cdb_valid, indices, new_values, pending_count
  );
endinterface

// File: rtl/cdb_broadcaster.sv
// CDB transmitter: per-FU result FIFOs drained by a round-robin arbiter
// onto four registered broadcast lanes.
module cdb_broadcaster #(
  parameter int NUM_FU      = 6,
  parameter int QUEUE_DEPTH = 2
) (
  input logic  clk,
  input logic  reset,
  input logic  flush,
  cdb_if.slave bus
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int FW = $clog2(NUM_FU);

  logic [19:0]       mem    [NUM_FU][QUEUE_DEPTH];
  logic [PW-1:0]     rd_ptr [NUM_FU];
  logic [PW-1:0]     wr_ptr [NUM_FU];
  logic [CW-1:0]     count  [NUM_FU];
  logic [FW-1:0]     rr_ptr;
  logic [FW-1:0]     rr_next;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] grant;
  logic [FW-1:0]     lane_fu   [4];
  logic [3:0]        lane_use;
  logic [19:0]       lane_data [4];
  logic [4:0]        pending_sum;

  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      bus.fu_ready[k] = (count[k] < CW'(QUEUE_DEPTH));
    end
    push = bus.fu_valid & bus.fu_ready;
  end

  // Scan from rr_ptr with explicit wrap; only pre-edge occupancy is eligible.
  always_comb begin : arb
    logic [FW:0]   sum;
    logic [FW-1:0] idx;
    logic [2:0]    n;
    grant    = '0;
    lane_use = '0;
    rr_next  = rr_ptr;
    n        = '0;
    sum      = '0;
    idx      = '0;
    for (int l = 0; l < 4; l++) lane_fu[l] = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      sum = {1'b0, rr_ptr} + (FW+1)'(i);
      if (sum >= (FW+1)'(NUM_FU)) sum = sum - (FW+1)'(NUM_FU);
      idx = sum[FW-1:0];
      if (count[idx] != '0 && n < 3'd4) begin
        grant[idx]        = 1'b1;
        lane_fu[n[1:0]]   = idx;
        lane_use[n[1:0]]  = 1'b1;
        n                 = n + 3'd1;
        rr_next           = (idx == FW'(NUM_FU - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      lane_data[l] = mem[lane_fu[l]][rd_ptr[lane_fu[l]]];
    end
  end

  always_comb begin
    pending_sum = '0;
    for (int k = 0; k < NUM_FU; k++) pending_sum = pending_sum + 5'(count[k]);
    bus.pending_count = pending_sum;
  end

  // Storage needs no reset; occupancy decides what is live.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_FU; k++) begin
      if (push[k]) mem[k][wr_ptr[k]] <= {bus.fu_indices[k], bus.fu_values[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int k = 0; k < NUM_FU; k++) begin
        count[k]  <= '0;
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
      end
      for (int l = 0; l < 4; l++) begin
        bus.cdb_valid[l]  <= 1'b0;
        bus.indices[l]    <= '0;
        bus.new_values[l] <= '0;
      end
      if (reset) rr_ptr <= '0;
    end else begin
      for (int k = 0; k < NUM_FU; k++) begin
        if (push[k])  wr_ptr[k] <= wr_ptr[k] + 1'b1;
        if (grant[k]) rd_ptr[k] <= rd_ptr[k] + 1'b1;
        count[k] <= count[k] + CW'(push[k]) - CW'(grant[k]);
      end
      for (int l = 0; l < 4; l++) begin
        bus.cdb_valid[l] <= lane_use[l];
        if (lane_use[l]) begin
          bus.indices[l]    <= lane_data[l][19:16];
          bus.new_values[l] <= lane_data[l][15:0];
        end
      end
      rr_ptr <= rr_next;
    end
  end
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed bench for cdb_broadcaster: hand-computed lane contents, occupancy,
// ready and flush/reset behaviour, plus a monitor for results that must never broadcast.
module tb_cdb_broadcaster;
  localparam int NUM_FU = 6;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   check_cnt = 0;
  int   pass_cnt  = 0;
  logic [15:0] forbid = '0;
  int   viol = 0;

  cdb_if #(.NUM_FU(NUM_FU)) bus ();

  cdb_broadcaster #(.NUM_FU(NUM_FU), .QUEUE_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (bus.cdb_valid[l] && forbid[bus.indices[l]]) viol++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    bus.fu_valid = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      bus.fu_indices[k] = '0;
      bus.fu_values[k]  = '0;
    end
  endtask

  task automatic push_one(input int k, input logic [3:0] idx, input logic [15:0] val);
    bus.fu_valid[k]   = 1'b1;
    bus.fu_indices[k] = idx;
    bus.fu_values[k]  = val;
  endtask

  task automatic push_all(input int idx_base, input logic [15:0] val_base);
    for (int k = 0; k < NUM_FU; k++) push_one(k, 4'(idx_base + k), val_base + 16'(k));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    clear_inputs();
    do_reset();
    check("rst_valid", 32'(bus.cdb_valid), 32'h0);
    check("rst_idx0", 32'(bus.indices[0]), 32'h0);
    check("rst_val3", 32'(bus.new_values[3]), 32'h0);
    check("rst_pending", 32'(bus.pending_count), 32'h0);
    check("rst_ready", 32'(bus.fu_ready), 32'h3f);

    // single push from FU2: visible only after the second edge
    push_one(2, 4'd5, 16'h1234);
    step();
    clear_inputs();
    check("t1_e1_valid", 32'(bus.cdb_valid), 32'h0);
    check("t1_e1_pending", 32'(bus.pending_count), 32'h1);
    step();
    check("t1_e2_valid", 32'(bus.cdb_valid), 32'h1);
    check("t1_e2_idx0", 32'(bus.indices[0]), 32'h5);
    check("t1_e2_val0", 32'(bus.new_values[0]), 32'h1234);
    check("t1_e2_pending", 32'(bus.pending_count), 32'h0);
    step();
    check("t1_e3_valid", 32'(bus.cdb_valid), 32'h0);
    check("t1_e3_idx0_hold", 32'(bus.indices[0]), 32'h5);

    // all six FUs at once, from rr_ptr = 0
    do_reset();
    push_all(0, 16'h0100);
    step();
    clear_inputs();
    check("t2_pending6", 32'(bus.pending_count), 32'h6);
    step();
    check("t2_c1_valid", 32'(bus.cdb_valid), 32'hf);
    check("t2_c1_idx0", 32'(bus.indices[0]), 32'h0);
    check("t2_c1_idx3", 32'(bus.indices[3]), 32'h3);
    check("t2_c1_val3", 32'(bus.new_values[3]), 32'h0103);
    check("t2_c1_pending", 32'(bus.pending_count), 32'h2);
    step();
    check("t2_c2_valid", 32'(bus.cdb_valid), 32'h3);
    check("t2_c2_idx0", 32'(bus.indices[0]), 32'h4);
    check("t2_c2_idx1", 32'(bus.indices[1]), 32'h5);
    check("t2_c2_val1", 32'(bus.new_values[1]), 32'h0105);
    check("t2_c2_idx2_hold", 32'(bus.indices[2]), 32'h2);
    check("t2_c2_pending", 32'(bus.pending_count), 32'h0);

    // FU0 streams three results; push and pop overlap
    push_one(0, 4'd8, 16'ha008);
    step();
    check("t3_b0_ready", 32'(bus.fu_ready[0]), 32'h1);
    push_one(0, 4'd9, 16'ha009);
    step();
    check("t3_b1_ready", 32'(bus.fu_ready[0]), 32'h1);
    check("t3_b1_idx0", 32'(bus.indices[0]), 32'h8);
    check("t3_b1_pending", 32'(bus.pending_count), 32'h1);
    push_one(0, 4'd10, 16'ha00a);
    step();
    clear_inputs();
    check("t3_b2_idx0", 32'(bus.indices[0]), 32'h9);
    check("t3_b2_val0", 32'(bus.new_values[0]), 32'ha009);
    step();
    check("t3_b3_valid", 32'(bus.cdb_valid), 32'h1);
    check("t3_b3_idx0", 32'(bus.indices[0]), 32'ha);
    check("t3_b3_pending", 32'(bus.pending_count), 32'h0);

    // saturate FU1 while rotation skips it (rr_ptr = 1 here)
    push_one(1, 4'd1, 16'h0301);
    step();
    push_all(0, 16'h0400);
    push_one(1, 4'd12, 16'h0401);
    step();
    clear_inputs();
    check("t4_c1_valid", 32'(bus.cdb_valid), 32'h1);
    check("t4_c1_idx0", 32'(bus.indices[0]), 32'h1);
    check("t4_c1_pending", 32'(bus.pending_count), 32'h6);
    push_one(1, 4'd13, 16'h0d0d);
    step();
    check("t4_c2_valid", 32'(bus.cdb_valid), 32'hf);
    check("t4_c2_idx0", 32'(bus.indices[0]), 32'h2);
    check("t4_c2_pending", 32'(bus.pending_count), 32'h3);
    check("t4_c2_ready", 32'(bus.fu_ready), 32'h3d);
    push_one(1, 4'd14, 16'h0e0e);
    step();
    clear_inputs();
    forbid[14] = 1'b1;
    check("t4_c3_valid", 32'(bus.cdb_valid), 32'h3);
    check("t4_c3_idx0", 32'(bus.indices[0]), 32'h0);
    check("t4_c3_idx1", 32'(bus.indices[1]), 32'hc);
    check("t4_c3_val1", 32'(bus.new_values[1]), 32'h0401);
    check("t4_c3_pending", 32'(bus.pending_count), 32'h1);
    step();
    check("t4_c4_valid", 32'(bus.cdb_valid), 32'h1);
    check("t4_c4_idx0", 32'(bus.indices[0]), 32'hd);
    check("t4_c4_pending", 32'(bus.pending_count), 32'h0);
    step();
    step();
    check("t4_no_drop_seen", 32'(viol), 32'h0);

    // build 8 pending entries (rr_ptr = 2), then flush
    push_all(0, 16'h0600);
    step();
    push_all(6, 16'h0700);
    step();
    clear_inputs();
    forbid = 16'b0101_1111_1100_0011;
    check("t5_pending8", 32'(bus.pending_count), 32'h8);
    check("t5_ready_full", 32'(bus.fu_ready), 32'h3c);
    check("t5_lanes_before", 32'(bus.indices[3]), 32'h5);
    flush = 1'b1;
    push_one(3, 4'd12, 16'h0c0c);
    step();
    flush = 1'b0;
    clear_inputs();
    check("t5_flush_valid", 32'(bus.cdb_valid), 32'h0);
    check("t5_flush_pending", 32'(bus.pending_count), 32'h0);
    check("t5_flush_ready", 32'(bus.fu_ready), 32'h3f);
    check("t5_flush_idx2", 32'(bus.indices[2]), 32'h0);
    step();
    step();
    step();
    check("t5_none_after_flush", 32'(viol), 32'h0);
    check("t5_still_empty", 32'(bus.pending_count), 32'h0);

    // reset with active lanes and pending entries (rr_ptr = 0 here)
    forbid = '0;
    push_all(0, 16'h0500);
    step();
    clear_inputs();
    step();
    check("t6_active_valid", 32'(bus.cdb_valid), 32'hf);
    check("t6_active_pending", 32'(bus.pending_count), 32'h2);
    forbid[4] = 1'b1;
    forbid[5] = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_valid", 32'(bus.cdb_valid), 32'h0);
    check("t6_rst_idx1", 32'(bus.indices[1]), 32'h0);
    check("t6_rst_val0", 32'(bus.new_values[0]), 32'h0);
    check("t6_rst_pending", 32'(bus.pending_count), 32'h0);
    check("t6_rst_ready", 32'(bus.fu_ready), 32'h3f);
    push_one(0, 4'd7, 16'h0700);
    push_one(5, 4'd8, 16'h0805);
    step();
    clear_inputs();
    step();
    check("t6_pair_valid", 32'(bus.cdb_valid), 32'h3);
    check("t6_pair_idx0", 32'(bus.indices[0]), 32'h7);
    check("t6_pair_idx1", 32'(bus.indices[1]), 32'h8);
    push_one(5, 4'd9, 16'h0909);
    step();
    clear_inputs();
    step();
    check("t6_fu5_valid", 32'(bus.cdb_valid), 32'h1);
    check("t6_fu5_idx0", 32'(bus.indices[0]), 32'h9);
    check("t6_fu5_val0", 32'(bus.new_values[0]), 32'h0909);
    step();
    check("t6_none_after_reset", 32'(viol), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
